// File: rtl/map_wr_arbiter_if.sv
// Request and map-port bundle for map_wr_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface map_wr_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
);
    logic                           map_ready;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_expect;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]             req_done;
    logic                           req_ok;
    logic [ADDR_WIDTH-1:0]          map_rd_addr;
    logic [DATA_WIDTH-1:0]          map_rd_data;
    logic                           map_we;
    logic [ADDR_WIDTH-1:0]          map_wr_addr;
    logic [DATA_WIDTH-1:0]          map_wr_data;
    logic                           busy;

    modport slave (
        input  map_ready, req_valid, req_addr, req_expect, req_data, map_rd_data,
        output req_done, req_ok, map_rd_addr, map_we, map_wr_addr, map_wr_data, busy
    );

    modport master (
        output map_ready, req_valid, req_addr, req_expect, req_data, map_rd_data,
        input  req_done, req_ok, map_rd_addr, map_we, map_wr_addr, map_wr_data, busy
    );
endinterface

// File: rtl/map_wr_arbiter.sv
// Round-robin compare-and-swap arbiter for the tile map write port.
// One atomic read-check-write in flight; 3 cycles per transaction.
module map_wr_arbiter #(
    parameter int NUM_ROW    = 13,
    parameter int NUM_COL    = 15,
    parameter int DATA_WIDTH = 2,
    parameter int NUM_REQ    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    map_wr_arbiter_if.slave bus
);
    localparam int DEPTH      = NUM_ROW * NUM_COL;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int IDX_W      = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP} state_t;

    state_t                                r_state;
    logic [IDX_W-1:0]                      r_ptr, r_idx;
    logic [NUM_REQ-1:0]                    r_done;
    logic                                  r_ok, r_we, r_busy;
    logic [ADDR_WIDTH-1:0]                 r_addr, r_rd_addr, r_wr_addr;
    logic [DATA_WIDTH-1:0]                 r_exp, r_data, r_wr_data;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    w_req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    w_req_exp, w_req_data;
    logic [NUM_REQ-1:0]                    w_elig;
    logic [IDX_W-1:0]                      w_cand, w_gnt_idx;
    logic                                  w_gnt_vld, w_match;

    assign w_req_addr = bus.req_addr;
    assign w_req_exp  = bus.req_expect;
    assign w_req_data = bus.req_data;

    // A requester in its own done cycle is masked so it cannot be re-granted.
    assign w_elig = bus.req_valid & ~r_done;

    // Descending scan so the nearest candidate after r_ptr wins last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (w_elig[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_match = (bus.map_rd_data == r_exp) && (int'(r_addr) < DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_idx     <= '0;
            r_addr    <= '0;
            r_exp     <= '0;
            r_data    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= '0;
            r_ok      <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= '0;
            r_ok   <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.map_ready && w_gnt_vld) begin
                        r_idx     <= w_gnt_idx;
                        r_ptr     <= w_gnt_idx;
                        r_addr    <= w_req_addr[w_gnt_idx];
                        r_exp     <= w_req_exp[w_gnt_idx];
                        r_data    <= w_req_data[w_gnt_idx];
                        r_rd_addr <= w_req_addr[w_gnt_idx];
                        r_busy    <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (!bus.map_ready) begin
                        r_done  <= NUM_REQ'(1) << r_idx;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_done  <= NUM_REQ'(1) << r_idx;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (bus.map_ready) begin
                        r_we      <= w_match;
                        r_ok      <= w_match;
                        r_wr_addr <= r_addr;
                        r_wr_data <= r_data;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_done    = r_done;
    assign bus.req_ok      = r_ok;
    assign bus.map_we      = r_we;
    assign bus.map_rd_addr = r_rd_addr;
    assign bus.map_wr_addr = r_wr_addr;
    assign bus.map_wr_data = r_wr_data;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_map_wr_arbiter.sv
// Self-checking bench for map_wr_arbiter: directed scenarios plus a random
// run scored against a transaction-level round-robin CAS model.
module tb_map_wr_arbiter;
    localparam int NUM_ROW = 13;
    localparam int NUM_COL = 15;
    localparam int DW      = 2;
    localparam int NR      = 3;
    localparam int DEPTH   = NUM_ROW * NUM_COL;
    localparam int AW      = $clog2(DEPTH);
    localparam int MSZ     = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    map_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    map_wr_arbiter #(.NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .DATA_WIDTH(DW), .NUM_REQ(NR))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Map memory: one synchronous read port, one write port, plus bench preload.
    logic [DW-1:0] mem [MSZ];
    logic          clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_addr] <= pl_data;
            if (bus.map_we) mem[bus.map_wr_addr] <= bus.map_wr_data;
        end
        rd_q <= mem[bus.map_rd_addr];
    end
    assign bus.map_rd_data = rd_q;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int cyc; int idx; bit ok; int addr; int data; } txn_t;

    task automatic set_req(input int i, input bit v, input int a, input int e, input int d);
        bus.req_valid[i]             = v;
        bus.req_addr[i*AW +: AW]     = AW'(a);
        bus.req_expect[i*DW +: DW]   = DW'(e);
        bus.req_data[i*DW +: DW]     = DW'(d);
    endtask

    task automatic test_reset();
        bus.map_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 0, 0, 0);
        rst_n = 1'b0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        n_chk++; if (bus.req_done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b want 000", bus.req_done); end
        n_chk++; if (bus.req_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", bus.req_ok); end
        n_chk++; if (bus.map_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.map_we); end
        n_chk++; if (bus.map_rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", bus.map_rd_addr); end
        n_chk++; if (bus.map_wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", bus.map_wr_addr); end
        n_chk++; if (bus.map_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0d want 0", bus.map_wr_data); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_place();
        set_req(0, 1'b1, 40, 0, 3);
        @(negedge clk);
        n_chk++; if (bus.map_rd_addr !== AW'(40)) begin n_fail++; $display("FAIL place_rd_addr: got %0d want 40", bus.map_rd_addr); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL place_busy_rd: got %b want 1", bus.busy); end
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1 || bus.map_we !== 1'b0) begin n_fail++; $display("FAIL place_cmp: busy %b we %b want 1 0", bus.busy, bus.map_we); end
        @(negedge clk);
        n_chk++; if (bus.map_we !== 1'b1 || bus.map_wr_addr !== AW'(40) || bus.map_wr_data !== DW'(3))
            begin n_fail++; $display("FAIL place_write: we %b addr %0d data %0d want 1 40 3", bus.map_we, bus.map_wr_addr, bus.map_wr_data); end
        n_chk++; if (bus.req_done !== 3'b001 || bus.req_ok !== 1'b1 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL place_done: done %b ok %b busy %b want 001 1 0", bus.req_done, bus.req_ok, bus.busy); end
        set_req(0, 1'b0, 40, 0, 3);
        @(negedge clk);
        n_chk++; if (mem[40] !== DW'(3)) begin n_fail++; $display("FAIL place_tile: got %0d want 3", mem[40]); end
        n_chk++; if (bus.req_done !== 3'b000 || bus.map_we !== 1'b0) begin n_fail++; $display("FAIL place_pulse: done %b we %b want 000 0", bus.req_done, bus.map_we); end
    endtask

    task automatic test_cas_fail();
        bit we_seen = 1'b0;
        pl_en = 1'b1; pl_addr = '0; pl_data = 2'd1;
        @(negedge clk);
        pl_en = 1'b0;
        set_req(1, 1'b1, 0, 2, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.map_we) we_seen = 1'b1;
            if (k == 3) begin
                n_chk++; if (bus.req_done !== 3'b010 || bus.req_ok !== 1'b0)
                    begin n_fail++; $display("FAIL cas_done: done %b ok %b want 010 0", bus.req_done, bus.req_ok); end
                set_req(1, 1'b0, 0, 2, 0);
            end
        end
        n_chk++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL cas_no_write: we seen %b want 0", we_seen); end
        n_chk++; if (mem[0] !== DW'(1)) begin n_fail++; $display("FAIL cas_tile: got %0d want 1", mem[0]); end
    endtask

    task automatic test_atomicity();
        logic [NR-1:0] d_seq [2];
        bit            ok_seq [2];
        int nd = 0;
        int we_cnt = 0;
        set_req(0, 1'b1, 22, 0, 3);
        set_req(1, 1'b1, 22, 0, 3);
        for (int k = 0; k < 20 && nd < 2; k++) begin
            @(negedge clk);
            if (bus.map_we) we_cnt++;
            if (bus.req_done != '0) begin
                d_seq[nd] = bus.req_done;
                ok_seq[nd] = bus.req_ok;
                for (int i = 0; i < NR; i++) if (bus.req_done[i]) bus.req_valid[i] = 1'b0;
                nd++;
            end
        end
        @(negedge clk);
        if (bus.map_we) we_cnt++;
        n_chk++;
        if (nd != 2) begin
            n_fail++; $display("FAIL atomic_timeout: dones %0d want 2", nd);
        end else begin
            if (d_seq[0] !== 3'b001 || ok_seq[0] !== 1'b1 || d_seq[1] !== 3'b010 || ok_seq[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL atomic_order: got %b/%b %b/%b want 001/1 010/0", d_seq[0], ok_seq[0], d_seq[1], ok_seq[1]);
            end
        end
        n_chk++; if (we_cnt != 1) begin n_fail++; $display("FAIL atomic_writes: got %0d want 1", we_cnt); end
        n_chk++; if (mem[22] !== DW'(3)) begin n_fail++; $display("FAIL atomic_tile: got %0d want 3", mem[22]); end
    endtask

    task automatic test_map_ready();
        bus.map_ready = 1'b0;
        set_req(2, 1'b1, 5, 0, 2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++; if (bus.busy !== 1'b0 || bus.req_done !== 3'b000)
                begin n_fail++; $display("FAIL ready_hold: busy %b done %b want 0 000", bus.busy, bus.req_done); end
        end
        bus.map_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1 || bus.map_rd_addr !== AW'(5))
            begin n_fail++; $display("FAIL ready_grant: busy %b rd_addr %0d want 1 5", bus.busy, bus.map_rd_addr); end
        @(negedge clk);
        bus.map_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.req_done !== 3'b100 || bus.req_ok !== 1'b0 || bus.map_we !== 1'b0)
            begin n_fail++; $display("FAIL ready_abort: done %b ok %b we %b want 100 0 0", bus.req_done, bus.req_ok, bus.map_we); end
        set_req(2, 1'b0, 5, 0, 2);
        bus.map_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.map_we !== 1'b0 || mem[5] !== DW'(0))
            begin n_fail++; $display("FAIL ready_no_write: we %b tile %0d want 0 0", bus.map_we, mem[5]); end
    endtask

    task automatic test_reset_mid_rd();
        int cnt = 0;
        bit got = 1'b0;
        set_req(2, 1'b1, 60, 0, 3);
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_rd_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.busy !== 1'b0 || bus.map_rd_addr !== '0 || bus.req_done !== 3'b000 || bus.req_ok !== 1'b0)
            begin n_fail++; $display("FAIL rst_async_a: busy %b rd %0d done %b ok %b want all 0", bus.busy, bus.map_rd_addr, bus.req_done, bus.req_ok); end
        n_chk++; if (bus.map_we !== 1'b0 || bus.map_wr_addr !== '0 || bus.map_wr_data !== '0)
            begin n_fail++; $display("FAIL rst_async_b: we %b wr_addr %0d wr_data %0d want all 0", bus.map_we, bus.map_wr_addr, bus.map_wr_data); end
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (mem[60] !== DW'(0)) begin n_fail++; $display("FAIL rst_no_write: tile %0d want 0", mem[60]); end
        rst_n = 1'b1;
        while (cnt < 10 && !got) begin
            @(negedge clk);
            cnt++;
            if (bus.req_done != '0) got = 1'b1;
        end
        n_chk++;
        if (!got || cnt != 3 || bus.req_done !== 3'b100 || bus.req_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reserve: done %b ok %b after %0d cycles want 100 1 after 3", bus.req_done, bus.req_ok, cnt);
        end
        set_req(2, 1'b0, 60, 0, 3);
        @(negedge clk);
        n_chk++; if (mem[60] !== DW'(3)) begin n_fail++; $display("FAIL rst_tile: got %0d want 3", mem[60]); end
    endtask

    task automatic test_contention();
        bit reraise [NR];
        int nd = 0;
        logic [NR-1:0] exp_d;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin set_req(i, 1'b1, 100 + i, 0, 0); reraise[i] = 1'b0; end
        for (int cyc = 1; cyc <= 40 && nd < 9; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (reraise[i]) begin bus.req_valid[i] = 1'b1; reraise[i] = 1'b0; end
            if (bus.req_done != '0) begin
                exp_d = NR'(1) << (nd % NR);
                n_chk++; if (bus.req_done !== exp_d || bus.req_ok !== 1'b1)
                    begin n_fail++; $display("FAIL rr_order: done %b ok %b want %b 1 (done #%0d)", bus.req_done, bus.req_ok, exp_d, nd); end
                n_chk++; if (cyc != 3 * (nd + 1))
                    begin n_fail++; $display("FAIL rr_timing: done #%0d at cycle %0d want %0d", nd, cyc, 3 * (nd + 1)); end
                for (int i = 0; i < NR; i++) if (bus.req_done[i]) begin bus.req_valid[i] = 1'b0; reraise[i] = 1'b1; end
                nd++;
            end
        end
        n_chk++; if (nd != 9) begin n_fail++; $display("FAIL rr_timeout: dones %0d want 9", nd); end
        for (int i = 0; i < NR; i++) bus.req_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [MSZ];
        txn_t q [$];
        txn_t e;
        int cool [NR];
        int rr = NR - 1;
        int busy_until = -1;
        int last_idx = -1;
        int last_grant = -100;
        logic [NR-1:0] exp_d;
        bit exp_ok, exp_busy, granted;
        rst_n = 1'b0;
        clr = 1'b1;
        for (int i = 0; i < NR; i++) begin set_req(i, 1'b0, 0, 0, 0); cool[i] = 0; end
        for (int i = 0; i < MSZ; i++) ref_mem[i] = '0;
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 900; cyc++) begin
            exp_d = '0; exp_ok = 1'b0;
            e = '{cyc: -1, idx: 0, ok: 1'b0, addr: 0, data: 0};
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                exp_d = NR'(1) << e.idx;
                exp_ok = e.ok;
            end
            exp_busy = (cyc == last_grant + 1) || (cyc == last_grant + 2);
            n_chk++; if (bus.req_done !== exp_d) begin n_fail++; $display("FAIL rnd_done @%0d: got %b want %b", cyc, bus.req_done, exp_d); end
            n_chk++; if (bus.req_ok !== exp_ok || bus.map_we !== exp_ok)
                begin n_fail++; $display("FAIL rnd_ok_we @%0d: ok %b we %b want %b", cyc, bus.req_ok, bus.map_we, exp_ok); end
            n_chk++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, bus.busy, exp_busy); end
            if (exp_ok) begin
                n_chk++; if (bus.map_wr_addr !== AW'(e.addr) || bus.map_wr_data !== DW'(e.data))
                    begin n_fail++; $display("FAIL rnd_wr @%0d: addr %0d data %0d want %0d %0d", cyc, bus.map_wr_addr, bus.map_wr_data, e.addr, e.data); end
            end
            // Requesters: drop on done, re-raise a fresh request after a random gap.
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_done[i]) begin
                    bus.req_valid[i] = 1'b0;
                    cool[i] = int'($urandom_range(0, 2));
                end else if (!bus.req_valid[i]) begin
                    if (cool[i] == 0)
                        set_req(i, 1'b1,
                                ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, MSZ - 1)) : int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    else
                        cool[i]--;
                end
            end
            @(posedge clk);
            // Transactions are serialized: each sees every earlier transaction's write.
            if (cyc >= busy_until) begin
                granted = 1'b0;
                for (int j = 1; j <= NR && !granted; j++) begin
                    int i, a, x, d;
                    i = (rr + j) % NR;
                    if (bus.req_valid[i] && !(cyc == busy_until && i == last_idx)) begin
                        a = int'(bus.req_addr[i*AW +: AW]);
                        x = int'(bus.req_expect[i*DW +: DW]);
                        d = int'(bus.req_data[i*DW +: DW]);
                        e.cyc = cyc + 3; e.idx = i; e.addr = a; e.data = d;
                        e.ok = (a < DEPTH) && (int'(ref_mem[a]) == x);
                        if (e.ok) ref_mem[a] = DW'(d);
                        q.push_back(e);
                        rr = i; last_idx = i; busy_until = cyc + 3; last_grant = cyc;
                        granted = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_place();
        test_cas_fail();
        test_atomicity();
        test_map_ready();
        test_reset_mid_rd();
        test_contention();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/map_wr_arbiter.md
# map_wr_arbiter

Arbitrates the single write port of the tile map memory between several gameplay requesters (player bomb placement, explosion tile clearing, bomb removal). Each request is a compare-and-swap. The block reads the tile through one map read port, compares it with the requester's expected value, and writes the new value only on a match. It sits between the gameplay logic and the map memory's second read port and write port, and guarantees one atomic read-check-write at a time.

## Interface
- NUM_ROW, MAP_NUM_ROW_DEF, tile grid rows
- NUM_COL, MAP_NUM_COL_DEF, tile grid columns
- DATA_WIDTH, MAP_MEM_WIDTH_DEF, tile entry width (tile codes: 0 no_blk, 1 perm_blk, 2 destroyable_blk, 3 bomb)
- NUM_REQ, 3, number of requesters (≥2)
- DEPTH = NUM_ROW*NUM_COL, ADDR_WIDTH = $clog2(DEPTH) (localparams)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous and active-low
- map_ready  in  1  high when the map memory accepts writes (not in reset-copy); driven by top level
- req_valid  in  NUM_REQ  per-requester request, held until its req_done
- req_addr  in  NUM_REQ*ADDR_WIDTH  tile address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_expect  in  NUM_REQ*DATA_WIDTH  required current tile value
- req_data  in  NUM_REQ*DATA_WIDTH  value to write on match
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_ok  out  1  qualifies req_done: 1 means the write was performed
- map_rd_addr  out  ADDR_WIDTH  to map read port (1-cycle synchronous read)
- map_rd_data  in  DATA_WIDTH  from map read port
- map_we, map_wr_addr, map_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  to the map write port
- busy  out  1  high while a transaction is in RD or CMP

## Operation
- FSM states:
  - IDLE: computes eligible = req_valid & ~req_done. If map_ready and eligible≠0, grants one requester. On grant, latches the index, addr, expect and data, registers map_rd_addr, and moves to RD.
  - RD: map memory samples map_rd_addr at the end of this cycle. Moves to CMP.
  - CMP: map_rd_data is valid and is compared with the latched expect. The block registers map_we = match, map_wr_addr/map_wr_data = latched addr/data, req_done[idx] = 1, and req_ok = match. Moves to IDLE.
- Round-robin arbitration: a pointer holds the last granted index. The search starts at pointer+1 mod NUM_REQ. The pointer updates on every grant.
- Address ≥ DEPTH: the transaction runs normally but the match is forced to 0, so no write occurs and req_ok=0.
- Abort: if map_ready is low in RD or CMP, the block returns to IDLE with map_we=0, and req_done[idx] pulses with req_ok=0 in the following cycle.
- Requester contract:
  - Hold valid/addr/expect/data stable from assertion until req_done.
  - Deassert valid in the req_done cycle or later. A requester is never re-granted in its own req_done cycle (masked).
  - A new request may be raised in any cycle after req_done.
- map_we, req_done and req_ok are single-cycle pulses, always 0 outside them. map_wr_addr/map_wr_data hold their last value.
- Comparison is an exact DATA_WIDTH equality. No arithmetic other than the modulo-NUM_REQ pointer.

## Timing
- Reset (rst_n low, asynchronous) takes effect immediately, mid-transaction included:
  - state IDLE, pointer NUM_REQ-1 (requester 0 has first priority);
  - all outputs 0: req_done, req_ok, map_we, map_rd_addr, map_wr_addr, map_wr_data, busy.
  - An in-flight transaction is discarded with no write and no done.
- Grant in cycle T (IDLE, sampled at the edge ending T): RD in T+1, CMP in T+2, and map_we/req_done/req_ok high in T+3.
- T+3 is IDLE again, so a new grant can occur in T+3. Throughput is one transaction per 3 cycles.
- Ordering: a write issued in T+3 lands at the end of T+3. The next transaction's read happens at the end of T+4. Back-to-back transactions to the same tile always see the prior write, so no forwarding is required.
- busy is high in T+1 and T+2.
- map_ready low in IDLE means no grant; requests wait indefinitely without being dropped.

## Test plan
- Single place: map all 0, req0 addr 40 expect 0 data 3 at T → map_rd_addr=40 in T+1; in T+3 map_we=1, addr 40, data 3, req_done=3'b001, req_ok=1; tile 40 reads 3 afterwards.
- CAS fail: tile 0 = 1, req1 addr 0 expect 2 data 0 → req_done=3'b010 at T+3 with req_ok=0; map_we never asserts.
- Contention: all three valid from first cycle after reset, each held through its done and re-raised one cycle later → grant order 0,1,2,0,…; dones at T+3, T+6, T+9; no requester is granted twice in a row while others wait.
- Atomicity: req0 and req1 both target addr 22 (tile 0) with expect 0 data 3, raised the same cycle → req0 ok=1 and tile becomes 3; req1 reads 3, gets ok=0, and no second write occurs.
- map_ready: low while req2 valid → no grant and busy=0. Then high → grant next cycle. Dropping map_ready during CMP → req_done with ok=0 and map_we=0.
- Reset mid-RD: rst_n low during RD → all outputs 0 in the same cycle with no write. After release, the still-held request is re-served starting from requester 0 priority.
